// File: rtl/rs_bank_sequencer_pkg.sv
// Shared definitions for the RS flip-flop bank sequencer: operation codes,
// FSM state encodings and small helpers that map an operation to R/S drive
// levels and to the Q value expected after the enable pulse.
package rs_bank_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SET  = 2'b01,
    OP_RST  = 2'b10,
    OP_TGL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

  // {R, S} for an operation given the Q sampled at grant. Never returns 2'b11.
  function automatic logic [1:0] rs_drive(op_e op, logic q0);
    case (op)
      OP_SET:  return 2'b01;
      OP_RST:  return 2'b10;
      OP_TGL:  return {q0, ~q0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic exp_q(op_e op, logic q0);
    case (op)
      OP_SET:  return 1'b1;
      OP_RST:  return 1'b0;
      OP_TGL:  return ~q0;
      default: return q0;
    endcase
  endfunction

endpackage

// File: rtl/rs_bank_sequencer_rr_arbiter2.sv
// 2-way round-robin arbiter.
//   req0/req1 : requests
//   advance   : grant is taken this cycle; the last-grant register updates
//   gnt_id    : winning requester (0/1), gnt_vld : any request present
// With both requesting, the one not granted last wins. Reset favours req0.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt_id,
  output logic gnt_vld
);

  logic last;

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_id  = (req0 & req1) ? ~last : req1;
  end

  always_ff @(posedge clk) begin
    if (rst)                     last <= 1'b1;
    else if (advance && gnt_vld) last <= gnt_id;
  end

endmodule

// File: rtl/rs_bank_sequencer.sv
// Sequencer/arbiter for a bank of RS flip-flops on a shared clock.
// Two requesters issue single-bit hold/set/reset/toggle ops; one is granted
// at a time and the target bit is driven SETUP -> PULSE -> HOLD -> CHECK,
// after which Q is compared with the expected result.
//   clk, rst        : clock, synchronous active-high reset
//   req/addr/op 0,1 : requests (held until done)
//   done/err 0,1    : one-cycle completion, err valid with done
//   ff_R/ff_S/ff_en : per-bit drive to the bank, ff_Q : per-bit readback
//   busy            : not IDLE
// All outputs decode from state and captured registers (plus live ff_Q for err).
module rs_bank_sequencer
  import rs_bank_sequencer_pkg::*;
#(
  parameter int N_BITS   = 8,
  parameter int ADDR_W   = 3,
  parameter int HOLD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [1:0]        op0,
  output logic              done0,
  output logic              err0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [1:0]        op1,
  output logic              done1,
  output logic              err1,
  output logic [N_BITS-1:0] ff_R,
  output logic [N_BITS-1:0] ff_S,
  output logic [N_BITS-1:0] ff_en,
  input  logic [N_BITS-1:0] ff_Q,
  output logic              busy
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [ADDR_W:0] NB = (ADDR_W+1)'(N_BITS);

  state_e            state, nxt;
  logic              cap_id, q0;
  logic [ADDR_W-1:0] cap_addr;
  op_e               cap_op;
  logic [HW-1:0]     hcnt;
  logic              gnt_id, gnt_vld;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .advance (state == ST_IDLE),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  // Q of the winner's target bit at grant; out-of-range addresses read as 0.
  logic [ADDR_W-1:0] win_addr;
  logic [N_BITS-1:0] q_win_sh, q_cap_sh;
  assign win_addr = gnt_id ? addr1 : addr0;
  assign q_win_sh = ff_Q >> win_addr;
  assign q_cap_sh = ff_Q >> cap_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cap_id   <= 1'b0;
      cap_addr <= '0;
      cap_op   <= OP_HOLD;
      q0       <= 1'b0;
      hcnt     <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && gnt_vld) begin
        cap_id   <= gnt_id;
        cap_addr <= win_addr;
        cap_op   <= op_e'(gnt_id ? op1 : op0);
        q0       <= ({1'b0, win_addr} < NB) ? q_win_sh[0] : 1'b0;
      end
      hcnt <= (state == ST_HOLD) ? hcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (gnt_vld) nxt = ST_SETUP;
      ST_SETUP: nxt = ST_PULSE;
      ST_PULSE: nxt = ST_HOLD;
      ST_HOLD:  if (hcnt == HW'(HOLD_CYC - 1)) nxt = ST_CHECK;
      ST_CHECK: nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // One-hot select of the captured bit; empty for a bad address so nothing
  // in the bank is ever touched.
  logic              addr_ok, drv, chk, mism;
  logic [1:0]        rs;
  logic [N_BITS-1:0] sel;

  always_comb begin
    addr_ok = ({1'b0, cap_addr} < NB);
    sel     = addr_ok ? (N_BITS'(1) << cap_addr) : '0;
    drv     = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD);
    chk     = (state == ST_CHECK);
    rs      = rs_drive(cap_op, q0);
    mism    = !addr_ok || (q_cap_sh[0] != exp_q(cap_op, q0));
    busy    = (state != ST_IDLE);
    done0   = chk && !cap_id;
    done1   = chk &&  cap_id;
    err0    = done0 && mism;
    err1    = done1 && mism;
  end

  for (genvar i = 0; i < N_BITS; i++) begin : g_bit
    assign ff_R[i]  = sel[i] & drv & rs[1];
    assign ff_S[i]  = sel[i] & drv & rs[0];
    assign ff_en[i] = sel[i] & (state == ST_PULSE);
  end

endmodule

// File: tb/tb_rs_bank_sequencer.sv
// Directed bench for rs_bank_sequencer with a 6-bit bank so that addresses
// 6 and 7 are out of range. A behavioural RS bank model answers ff_Q; bit 2
// can be pinned low to force a readback mismatch.
module tb_rs_bank_sequencer;

  localparam int NB = 6;
  localparam int AW = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req0 = 0, req1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [1:0]    op0 = '0, op1 = '0;
  logic          done0, err0, done1, err1, busy;
  logic [NB-1:0] ff_R, ff_S, ff_en, ff_Q;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  rs_bank_sequencer #(.N_BITS(NB), .ADDR_W(AW), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .op0(op0), .done0(done0), .err0(err0),
    .req1(req1), .addr1(addr1), .op1(op1), .done1(done1), .err1(err1),
    .ff_R(ff_R), .ff_S(ff_S), .ff_en(ff_en), .ff_Q(ff_Q), .busy(busy)
  );

  // RS bank model with a preload port driven by the stimulus.
  logic [NB-1:0] qm = '0;
  logic [NB-1:0] pin_lo = '0;
  logic          ld = 0, ld_val = 0;
  logic [AW-1:0] ld_addr = '0;
  assign ff_Q = qm & ~pin_lo;

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (ld && int'(ld_addr) == i) qm[i] <= ld_val;
      else if (ff_en[i]) begin
        if (ff_S[i])      qm[i] <= 1'b1;
        else if (ff_R[i]) qm[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Invariants every cycle.
  always @(negedge clk) begin
    chk("inv_rs_overlap", 32'(ff_R & ff_S), 32'd0);
    chk("inv_en_onehot", 32'($countones(ff_en) <= 1), 32'd1);
  end

  typedef struct {
    logic          id;
    logic [AW-1:0] addr;
    logic [1:0]    op;
    logic          qi;
    logic          pin;
    logic          er, es, eq, ee;
  } vec_t;

  vec_t tv[8];

  task automatic preload(input logic [AW-1:0] a, input logic v);
    ld = 1; ld_addr = a; ld_val = v;
    @(negedge clk);
    ld = 0;
  endtask

  // Runs one request from an IDLE negedge through CHECK and the IDLE after it.
  task automatic txn(input vec_t v);
    logic [NB-1:0] sel, er_v, es_v;
    sel  = (int'(v.addr) < NB) ? (NB'(1) << v.addr) : '0;
    er_v = v.er ? sel : '0;
    es_v = v.es ? sel : '0;
    if (v.id) begin req1 = 1; addr1 = v.addr; op1 = v.op; end
    else      begin req0 = 1; addr0 = v.addr; op0 = v.op; end
    @(negedge clk);
    chk("setup_busy", 32'(busy), 32'd1);
    chk("setup_R", 32'(ff_R), 32'(er_v));
    chk("setup_S", 32'(ff_S), 32'(es_v));
    chk("setup_en", 32'(ff_en), 32'd0);
    chk("setup_done", 32'({done1, done0}), 32'd0);
    @(negedge clk);
    chk("pulse_en", 32'(ff_en), 32'(sel));
    chk("pulse_RS", 32'({ff_R, ff_S}), 32'({er_v, es_v}));
    @(negedge clk);
    chk("hold_en", 32'(ff_en), 32'd0);
    chk("hold_RS", 32'({ff_R, ff_S}), 32'({er_v, es_v}));
    @(negedge clk);
    chk("check_done", 32'({done1, done0}), v.id ? 32'd2 : 32'd1);
    chk("check_err", 32'({err1, err0}), v.ee ? (v.id ? 32'd2 : 32'd1) : 32'd0);
    chk("check_drive", 32'({ff_R, ff_S, ff_en}), 32'd0);
    if (int'(v.addr) < NB) chk("check_q", 32'(ff_Q[v.addr]), 32'(v.eq));
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'({done1, done0}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //       id   addr  op     qi pin er es eq ee
    tv[0] = '{1'b0, 3'd3, 2'b01, 0, 0, 0, 1, 1, 0}; // set bit 3
    tv[1] = '{1'b0, 3'd5, 2'b11, 1, 0, 1, 0, 0, 0}; // toggle 1 -> 0
    tv[2] = '{1'b1, 3'd5, 2'b00, 0, 0, 0, 0, 0, 0}; // hold keeps 0
    tv[3] = '{1'b0, 3'd2, 2'b01, 0, 1, 0, 1, 0, 1}; // pinned low -> err
    tv[4] = '{1'b1, 3'd7, 2'b01, 0, 0, 0, 0, 0, 1}; // bad address
    tv[5] = '{1'b1, 3'd6, 2'b10, 0, 0, 0, 0, 0, 1}; // first bad address
    tv[6] = '{1'b1, 3'd1, 2'b10, 1, 0, 1, 0, 0, 0}; // reset 1 -> 0
    tv[7] = '{1'b0, 3'd0, 2'b11, 0, 0, 0, 1, 1, 0}; // toggle 0 -> 1

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drive", 32'({ff_R, ff_S, ff_en}), 32'd0);
    chk("rst_done_err", 32'({done0, done1, err0, err1}), 32'd0);
    rst = 0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      pin_lo = tv[k].pin ? (NB'(1) << tv[k].addr) : '0;
      // hold vector keeps the Q left by the preceding toggle
      if (int'(tv[k].addr) < NB && tv[k].op != 2'b00) preload(tv[k].addr, tv[k].qi);
      txn(tv[k]);
    end
    pin_lo = '0;

    // Contention after reset: grants 0,1,0 with one IDLE cycle between.
    rst = 1; @(negedge clk); rst = 0;
    req0 = 1; addr0 = 3'd0; op0 = 2'b01;
    req1 = 1; addr1 = 3'd1; op1 = 2'b01;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!(done0 || done1) && n < 10);
      chk("cont_done_seen", 32'(n < 10), 32'd1);
      chk("cont_winner", 32'({done1, done0}), (k == 1) ? 32'd2 : 32'd1);
      chk("cont_err", 32'({err1, err0}), 32'd0);
      if (k == 2) begin req0 = 0; req1 = 0; end
      @(negedge clk);
      chk("cont_idle", 32'({busy, done1, done0}), 32'd0);
      @(negedge clk);
      chk("cont_rearb", 32'(busy), (k < 2) ? 32'd1 : 32'd0);
    end

    // Reset in PULSE: transaction lost, then req1 is served normally.
    req0 = 1; addr0 = 3'd4; op0 = 2'b01;
    @(negedge clk);
    chk("rp_setup_S", 32'(ff_S), 32'(NB'(1) << 4));
    @(negedge clk);
    chk("rp_pulse_en", 32'(ff_en), 32'(NB'(1) << 4));
    rst = 1; req0 = 0;
    @(negedge clk);
    chk("rp_drive", 32'({ff_R, ff_S, ff_en}), 32'd0);
    chk("rp_busy", 32'(busy), 32'd0);
    chk("rp_done", 32'({done1, done0}), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("rp_no_done", 32'({done1, done0, busy}), 32'd0);
    preload(3'd4, 1'b1);
    txn('{1'b1, 3'd4, 2'b10, 1, 0, 1, 0, 0, 0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
